// File: rtl/cache_refill_ctrl.sv
// Miss handler for a direct-mapped, write-through cache: refills whole lines from a
// fixed-latency BRAM in offset order 0..3 and forwards every store to main memory.
module cache_refill_ctrl #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int OFFSET_W    = 2,
  parameter int MEM_LATENCY = 1
) (
  input  logic              clk_100,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] wdata,
  input  logic              hit,
  output logic              stall,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  output logic              mem_wr_en,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              fill_en,
  output logic [ADDR_W-1:0] fill_addr,
  output logic [DATA_W-1:0] fill_data,
  output logic              fill_done,
  output logic              busy
);

  localparam int LINE_W = ADDR_W - OFFSET_W;
  localparam logic [OFFSET_W-1:0] ONE  = OFFSET_W'(1);
  localparam logic [OFFSET_W-1:0] LAST = '1;

  typedef enum logic [2:0] {IDLE, WRITE, FETCH, DRAIN, DONE} state_t;

  state_t                r_state, w_stateNext;
  logic [LINE_W-1:0]     r_line, w_lineNext;
  logic [OFFSET_W-1:0]   r_issueCnt, w_issueCntNext;
  logic [OFFSET_W-1:0]   r_retCnt, w_retCntNext;
  logic [MEM_LATENCY-1:0] r_retPipe;
  logic                  r_memRdEn, w_memRdEnNext;
  logic                  r_memWrEn, w_memWrEnNext;
  logic                  r_fillDone, w_fillDoneNext;
  logic [ADDR_W-1:0]     r_memAddr, w_memAddrNext;
  logic [DATA_W-1:0]     r_memWdata, w_memWdataNext;
  logic                  w_store, w_miss, w_fillEn, w_lastRet;
  logic [OFFSET_W-1:0]   w_issueInc, w_retInc;

  assign w_store    = (r_state == IDLE) && req_valid && req_write;
  assign w_miss     = (r_state == IDLE) && req_valid && !req_write && !hit;
  assign w_fillEn   = r_retPipe[MEM_LATENCY-1];
  assign w_lastRet  = w_fillEn && (r_retCnt == LAST);
  assign w_issueInc = r_issueCnt + ONE;
  assign w_retInc   = r_retCnt + ONE;

  // r_issueCnt is the offset of the read currently on the memory bus
  always_comb begin
    w_stateNext    = r_state;
    w_lineNext     = r_line;
    w_issueCntNext = r_issueCnt;
    w_retCntNext   = w_fillEn ? w_retInc : r_retCnt;
    w_memRdEnNext  = 1'b0;
    w_memWrEnNext  = 1'b0;
    w_memAddrNext  = r_memAddr;
    w_memWdataNext = r_memWdata;
    w_fillDoneNext = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_store) begin
          w_stateNext    = WRITE;
          w_memWrEnNext  = 1'b1;
          w_memAddrNext  = addr_in;
          w_memWdataNext = wdata;
        end else if (w_miss) begin
          w_stateNext    = FETCH;
          w_lineNext     = addr_in[ADDR_W-1:OFFSET_W];
          w_issueCntNext = '0;
          w_retCntNext   = '0;
          w_memRdEnNext  = 1'b1;
          w_memAddrNext  = {addr_in[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
        end
      end
      WRITE: w_stateNext = IDLE;
      FETCH: begin
        if (r_issueCnt == LAST) begin
          w_stateNext    = w_lastRet ? DONE : DRAIN;
          w_fillDoneNext = w_lastRet;
        end else begin
          w_issueCntNext = w_issueInc;
          w_memRdEnNext  = 1'b1;
          w_memAddrNext  = {r_line, w_issueInc};
        end
      end
      DRAIN: begin
        if (w_lastRet) begin
          w_stateNext    = DONE;
          w_fillDoneNext = 1'b1;
        end
      end
      DONE:    w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
  end

  // Clearing the return pipeline on reset drops in-flight reads, so an aborted line never fills
  always_ff @(posedge clk_100) begin
    if (rst) begin
      r_state    <= IDLE;
      r_line     <= '0;
      r_issueCnt <= '0;
      r_retCnt   <= '0;
      r_retPipe  <= '0;
      r_memRdEn  <= 1'b0;
      r_memWrEn  <= 1'b0;
      r_fillDone <= 1'b0;
      r_memAddr  <= '0;
      r_memWdata <= '0;
    end else begin
      r_state    <= w_stateNext;
      r_line     <= w_lineNext;
      r_issueCnt <= w_issueCntNext;
      r_retCnt   <= w_retCntNext;
      r_memRdEn  <= w_memRdEnNext;
      r_memWrEn  <= w_memWrEnNext;
      r_fillDone <= w_fillDoneNext;
      r_memAddr  <= w_memAddrNext;
      r_memWdata <= w_memWdataNext;
      r_retPipe[0] <= r_memRdEn;
      for (int i = 1; i < MEM_LATENCY; i++) begin
        r_retPipe[i] <= r_retPipe[i-1];
      end
    end
  end

  assign stall     = ((r_state != IDLE) && (r_state != DONE)) || w_store || w_miss;
  assign busy      = (r_state != IDLE);
  assign mem_rd_en = r_memRdEn;
  assign mem_wr_en = r_memWrEn;
  assign mem_addr  = r_memAddr;
  assign mem_wdata = r_memWdata;
  assign fill_done = r_fillDone;
  // Fill word is taken straight off the BRAM output in the cycle its tag emerges
  assign fill_en   = w_fillEn;
  assign fill_addr = w_fillEn ? {r_line, r_retCnt} : '0;
  assign fill_data = w_fillEn ? mem_rdata : '0;

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Bench for cache_refill_ctrl: latency-1 and latency-3 instances share stimulus, each
// checked every cycle against a timeline model of the store/miss protocol.
module tb_cache_refill_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        reqValid = 1'b1;
  logic        reqWrite = 1'b0;
  logic        hit = 1'b0;
  logic [15:0] addrIn = 16'h0000;
  logic [15:0] wdata = 16'h0000;

  logic        stallW    [2];
  logic        busyW     [2];
  logic        memRdW    [2];
  logic        memWrW    [2];
  logic        fillEnW   [2];
  logic        fillDoneW [2];
  logic [15:0] memAddrW  [2];
  logic [15:0] memWdataW [2];
  logic [15:0] memRdataW [2];
  logic [15:0] fillAddrW [2];
  logic [15:0] fillDataW [2];

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int unit, input logic [15:0] act,
                             input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s dut%0d cycle %0d: got %h, expected %h", name, unit, cyc, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic rv, input logic wr,
                               input logic [15:0] a, input logic [15:0] wd, input logic h);
    @(posedge clock);
    #1;
    reset    = r;
    reqValid = rv;
    reqWrite = wr;
    addrIn   = a;
    wdata    = wd;
    hit      = h;
  endtask

  task automatic waitIdle();
    int n = 0;
    while ((busyW[0] || busyW[1]) && n < 60) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
      @(negedge clock);
      n++;
    end
    if (busyW[0] || busyW[1]) begin
      checks++;
      fails++;
      $display("[TB] FAIL waitIdle: still busy after %0d cycles, required idle", n);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : gLat
    localparam int L = (g == 0) ? 1 : 3;

    logic [15:0] rdPipe [L];
    int          t0 = 0;
    int          busyEnd = -1;
    bit          isStore = 1'b0;
    bit          modelOn = 1'b0;
    logic [15:0] lineBase = 16'h0;
    logic [15:0] stAddr = 16'h0;
    logic [15:0] stData = 16'h0;

    cache_refill_ctrl #(.MEM_LATENCY(L)) u_dut (
      .clk_100  (clock),
      .rst      (reset),
      .req_valid(reqValid),
      .req_write(reqWrite),
      .addr_in  (addrIn),
      .wdata    (wdata),
      .hit      (hit),
      .stall    (stallW[g]),
      .mem_addr (memAddrW[g]),
      .mem_rd_en(memRdW[g]),
      .mem_wr_en(memWrW[g]),
      .mem_wdata(memWdataW[g]),
      .mem_rdata(memRdataW[g]),
      .fill_en  (fillEnW[g]),
      .fill_addr(fillAddrW[g]),
      .fill_data(fillDataW[g]),
      .fill_done(fillDoneW[g]),
      .busy     (busyW[g])
    );

    // BRAM stand-in: word at address a is a ^ A5A5, returned L cycles after the strobe
    always @(posedge clock) begin
      rdPipe[0] <= memRdW[g] ? (memAddrW[g] ^ 16'hA5A5) : 16'h0000;
      for (int i = 1; i < L; i++) rdPipe[i] <= rdPipe[i-1];
    end
    assign memRdataW[g] = rdPipe[L-1];

    // Expected outputs follow from the cycle offset d since the request was accepted
    always @(negedge clock) begin : model
      int          d;
      logic        eStall, eBusy, eRd, eWr, eFill, eDone;
      logic [15:0] eMemAddr, eFillAddr;
      if (modelOn) begin
        d = cyc - t0;
        eStall = 1'b0; eBusy = 1'b0; eRd = 1'b0; eWr = 1'b0; eFill = 1'b0; eDone = 1'b0;
        eMemAddr = 16'h0; eFillAddr = 16'h0;
        if (cyc > busyEnd) begin
          eStall = reqValid && (reqWrite || !hit);
        end else if (isStore) begin
          eBusy = 1'b1; eStall = 1'b1; eWr = 1'b1; eMemAddr = stAddr;
        end else begin
          eBusy     = 1'b1;
          eStall    = (d <= 4 + L);
          eRd       = (d >= 1) && (d <= 4);
          eMemAddr  = lineBase + 16'(d - 1);
          eFill     = (d >= 1 + L) && (d <= 4 + L);
          eFillAddr = lineBase + 16'(d - 1 - L);
          eDone     = (d == 5 + L);
        end
        checkOutput("stall", g, 16'(stallW[g]), 16'(eStall));
        checkOutput("busy", g, 16'(busyW[g]), 16'(eBusy));
        checkOutput("mem_rd_en", g, 16'(memRdW[g]), 16'(eRd));
        checkOutput("mem_wr_en", g, 16'(memWrW[g]), 16'(eWr));
        checkOutput("fill_en", g, 16'(fillEnW[g]), 16'(eFill));
        checkOutput("fill_done", g, 16'(fillDoneW[g]), 16'(eDone));
        if (eRd || eWr) checkOutput("mem_addr", g, memAddrW[g], eMemAddr);
        if (eWr) checkOutput("mem_wdata", g, memWdataW[g], stData);
        if (eFill) begin
          checkOutput("fill_addr", g, fillAddrW[g], eFillAddr);
          checkOutput("fill_data", g, fillDataW[g], eFillAddr ^ 16'hA5A5);
        end
      end
      if (reset) begin
        modelOn = 1'b1;
        busyEnd = -1;
      end else if (modelOn && cyc > busyEnd && reqValid && (reqWrite || !hit)) begin
        t0 = cyc;
        isStore = reqWrite;
        if (reqWrite) begin
          busyEnd = cyc + 1;
          stAddr  = addrIn;
          stData  = wdata;
        end else begin
          busyEnd  = cyc + 5 + L;
          lineBase = {addrIn[15:2], 2'b00};
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, %0d checks so far", checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cnt;
    // Reset held two cycles with a pending request, then released idle
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0, 16'h0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0, 16'h0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    @(negedge clock);
    for (int u = 0; u < 2; u++) begin
      checkOutput("rst stall", u, 16'(stallW[u]), 16'h0);
      checkOutput("rst busy", u, 16'(busyW[u]), 16'h0);
      checkOutput("rst strobes", u, 16'({memRdW[u], memWrW[u], fillEnW[u], fillDoneW[u]}), 16'h0);
      checkOutput("rst mem_addr", u, memAddrW[u], 16'h0);
      checkOutput("rst fill_addr", u, fillAddrW[u], 16'h0);
    end

    // Read miss at F005
    applyStimulus(1'b0, 1'b1, 1'b0, 16'hF005, 16'h0, 1'b0);
    for (int k = 0; k <= 8; k++) begin
      @(negedge clock);
      if (k == 0) begin
        checkOutput("miss stall c0", 0, 16'(stallW[0]), 16'h1);
        checkOutput("miss busy c0", 0, 16'(busyW[0]), 16'h0);
      end
      if (k == 1) checkOutput("miss addr c1", 0, memAddrW[0], 16'hF004);
      if (k == 4) checkOutput("miss addr c4", 0, memAddrW[0], 16'hF007);
      if (k == 2) begin
        checkOutput("miss fill_en c2", 0, 16'(fillEnW[0]), 16'h1);
        checkOutput("miss fill_addr c2", 0, fillAddrW[0], 16'hF004);
        checkOutput("miss fill_data c2", 0, fillDataW[0], 16'h55A1);
      end
      if (k == 5) begin
        checkOutput("miss fill_addr c5", 0, fillAddrW[0], 16'hF007);
        checkOutput("miss fill_data c5", 0, fillDataW[0], 16'h55A2);
        checkOutput("miss stall c5", 0, 16'(stallW[0]), 16'h1);
      end
      if (k == 6) begin
        checkOutput("miss fill_done c6", 0, 16'(fillDoneW[0]), 16'h1);
        checkOutput("miss stall c6", 0, 16'(stallW[0]), 16'h0);
      end
      if (k == 8) checkOutput("miss L3 fill_done c8", 1, 16'(fillDoneW[1]), 16'h1);
      applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    end
    @(negedge clock);
    waitIdle();

    // Read hit
    applyStimulus(1'b0, 1'b1, 1'b0, 16'hF005, 16'h0, 1'b1);
    @(negedge clock);
    checkOutput("hit stall", 0, 16'(stallW[0]), 16'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    @(negedge clock);
    checkOutput("hit busy", 0, 16'(busyW[0]), 16'h0);
    checkOutput("hit rd_en", 0, 16'(memRdW[0]), 16'h0);

    // Store
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h1234, 16'hBEEF, 1'b0);
    @(negedge clock);
    checkOutput("store stall c0", 0, 16'(stallW[0]), 16'h1);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    @(negedge clock);
    checkOutput("store wr_en c1", 0, 16'(memWrW[0]), 16'h1);
    checkOutput("store addr c1", 0, memAddrW[0], 16'h1234);
    checkOutput("store wdata c1", 0, memWdataW[0], 16'hBEEF);
    checkOutput("store fill_en c1", 0, 16'(fillEnW[0]), 16'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    @(negedge clock);
    checkOutput("store busy c2", 0, 16'(busyW[0]), 16'h0);

    // Latency-3 miss at 00FF
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h00FF, 16'h0, 1'b0);
    for (int k = 0; k <= 8; k++) begin
      @(negedge clock);
      if (k == 1) checkOutput("L3 addr c1", 1, memAddrW[1], 16'h00FC);
      if (k == 3) checkOutput("L3 fill_en c3", 1, 16'(fillEnW[1]), 16'h0);
      if (k == 4) begin
        checkOutput("L3 addr c4", 1, memAddrW[1], 16'h00FF);
        checkOutput("L3 fill_addr c4", 1, fillAddrW[1], 16'h00FC);
        checkOutput("L3 fill_data c4", 1, fillDataW[1], 16'hA559);
      end
      if (k == 7) begin
        checkOutput("L3 fill_addr c7", 1, fillAddrW[1], 16'h00FF);
        checkOutput("L3 fill_data c7", 1, fillDataW[1], 16'hA55A);
      end
      if (k == 8) checkOutput("L3 fill_done c8", 1, 16'(fillDoneW[1]), 16'h1);
      applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    end
    @(negedge clock);
    waitIdle();

    // Reset in cycle 3 of a miss, then a clean miss at 0040
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h3339, 16'h0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      for (int u = 0; u < 2; u++) if (fillEnW[u] || fillDoneW[u]) cnt++;
      applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    end
    checkOutput("abort fills", 0, 16'(cnt), 16'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0040, 16'h0, 1'b0);
    for (int k = 0; k <= 2; k++) begin
      @(negedge clock);
      if (k == 1) checkOutput("refill addr c1", 0, memAddrW[0], 16'h0040);
      if (k == 2) begin
        checkOutput("refill fill_addr c2", 0, fillAddrW[0], 16'h0040);
        checkOutput("refill fill_data c2", 0, fillDataW[0], 16'hA5E5);
      end
      applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    end
    @(negedge clock);
    waitIdle();

    // Random traffic with occasional resets
    for (int i = 0; i < 1500; i++) begin
      applyStimulus($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0,
                    $urandom_range(0, 2) == 0, 16'($urandom), 16'($urandom),
                    $urandom_range(0, 1) == 1);
      @(negedge clock);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    @(negedge clock);
    waitIdle();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/cache_refill_ctrl.md
Name: cache_refill_ctrl

Overview:
Miss handler and write-through engine directly downstream of the direct-mapped cache (16-bit address = 8-bit tag, 6-bit index, 2-bit word offset; 4-word lines). On a read miss it stalls the core, fetches the 4-word line from main memory (synchronous BRAM) and streams it into the cache fill port. On every write it forwards the word to main memory; the cache is write-through with no write-allocate.

Parameters:
ADDR_W, 16, address width
DATA_W, 16, data word width
OFFSET_W, 2, word-offset bits; line = 2**OFFSET_W words
MEM_LATENCY, 1, cycles from mem_rd_en to valid mem_rdata (1..4)

Ports:
clk_100  in  1  system clock; all logic on rising edge
rst  in  1  synchronous active-high reset
req_valid  in  1  core memory request this cycle
req_write  in  1  1 = store, 0 = load
addr_in  in  ADDR_W  request address (same value the cache sees)
wdata  in  DATA_W  store data
hit  in  1  cache hit for addr_in, combinational from cache
stall  out  1  freeze core / hold addr_in
mem_addr  out  ADDR_W  main memory address
mem_rd_en  out  1  main memory read strobe
mem_wr_en  out  1  main memory write strobe
mem_wdata  out  DATA_W  main memory write data
mem_rdata  in  DATA_W  main memory read data
fill_en  out  1  write one word into cache data/tag arrays
fill_addr  out  ADDR_W  full address of filled word (tag+index+offset)
fill_data  out  DATA_W  word to fill
fill_done  out  1  one-cycle pulse: line complete, cache valid bit set
busy  out  1  state != IDLE

Behaviour:
- Reset (rst=1 at clock edge): state=IDLE, counters=0, return pipeline cleared; registered outputs mem_rd_en, mem_wr_en, fill_en, fill_done = 0; mem_addr, mem_wdata, fill_addr, fill_data = 0. Reset mid-refill aborts: in-flight returns discarded, no fill_en after reset, partial line never marked valid (no fill_done).
- stall (combinational) = (state != IDLE && state != DONE) || (state == IDLE && req_valid && (req_write || !hit)).
- States: IDLE, WRITE, FETCH, DRAIN, DONE.
- IDLE: req_valid && req_write -> latch addr/wdata, WRITE. req_valid && !req_write && !hit -> latch base = {addr_in[15:2], 2'b00}, issue_cnt=0, ret_cnt=0, FETCH. Read hit or no request -> stay; stall=0.
- WRITE (1 cycle): mem_wr_en=1, mem_addr=latched addr, mem_wdata=latched wdata; next IDLE. Store completes 1 cycle after acceptance; core re-presents nothing.
- FETCH: each cycle mem_rd_en=1, mem_addr=base+issue_cnt, issue_cnt++; after issue_cnt=3 issued -> DRAIN (if MEM_LATENCY returns still pending) else DONE.
- Returns: valid shift pipeline of depth MEM_LATENCY tags each read; when a return arrives, fill_en=1, fill_data=mem_rdata, fill_addr=base+ret_cnt, ret_cnt++ (modulo 4, 2-bit wrap). Returns are consumed in FETCH and DRAIN alike.
- DRAIN: wait until ret_cnt wraps after 4th return -> DONE.
- DONE (1 cycle): fill_done=1, stall=0, busy=1; next IDLE. Core re-looks-up and hits.
- Miss timing, MEM_LATENCY=L, miss seen cycle 0: reads issued cycles 1-4, fill_en cycles 1+L..4+L, DONE/fill_done cycle 5+L; stall high cycles 0..4+L.
- Requests arriving while busy are ignored (core is stalled, so they are the held request); no queuing.
- Offset wrap: base always line-aligned; fill order offset 0,1,2,3 regardless of requested offset.
- mem_rd_en and mem_wr_en never asserted in the same cycle.

Test Plan:
- Reset: hold rst 2 cycles with req_valid=1 -> all strobes 0, busy=0, stall=0 after release with req_valid=0.
- Read miss addr_in=16'hF005, hit=0, L=1, mem returns addr^16'hA5A5 -> mem_addr F004..F007 cycles 1-4, fill_en cycles 2-5 with fill_addr F004..F007 and matching data, fill_done cycle 6, stall 0..5.
- Read hit addr 16'hF005, hit=1 -> stall=0, no memory strobes, state stays IDLE.
- Store addr 16'h1234 wdata 16'hBEEF -> stall 1 cycle, next cycle mem_wr_en=1, mem_addr 1234, mem_wdata BEEF; no fill_en.
- MEM_LATENCY=3 read miss at 16'h00FF -> issues 00FC..00FF cycles 1-4, fills cycles 4-7, fill_done cycle 8.
- rst asserted at cycle 3 of a miss -> no fill_en/fill_done afterwards, subsequent miss to 16'h0040 refills cleanly from offset 0.
